// File: rtl/mem_branch_resolver.sv
// MEM-stage control-transfer resolver: registered PC redirect, fixed-length
// flush of the younger pipeline registers, and saturating branch statistics.
module mem_branch_resolver #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_valid,
    input  logic             stall,
    input  logic             Jump,
    input  logic             Branch,
    input  logic             InverseBranch,
    input  logic             Zero,
    input  logic [XLEN-1:0]  jump_target,
    input  logic             cnt_clear,
    output logic             pc_redirect_valid,
    output logic [XLEN-1:0]  pc_redirect_target,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             busy,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    localparam int unsigned FcW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRedirect,
        StFlush
    } state_e;

    state_e           state_q, state_d;
    logic [FcW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]  target_q, target_d;
    logic [CNT_W-1:0] branch_q, branch_d;
    logic [CNT_W-1:0] taken_q, taken_d;
    logic             accept;
    logic             taken;

    always_comb begin
        accept   = mem_valid & ~stall & (state_q == StIdle);
        // Jump wins over Branch, so the condition only matters for a pure branch.
        taken    = Jump | (Branch & (Zero ^ InverseBranch));
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        branch_d = branch_q;
        taken_d  = taken_q;

        unique case (state_q)
            StIdle: begin
                if (accept && taken) begin
                    target_d = {jump_target[XLEN-1:1], 1'b0};
                    state_d  = StRedirect;
                end
            end
            StRedirect: begin
                if (!stall) begin
                    if (FLUSH_CYCLES == 1) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d   = FcW'(FLUSH_CYCLES - 1);
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                if (!stall) begin
                    cnt_d = cnt_q - FcW'(1);
                    if (cnt_q == FcW'(1)) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (cnt_clear) begin
            branch_d = '0;
            taken_d  = '0;
        end else if (accept) begin
            if (Branch && !Jump && !(&branch_q)) begin
                branch_d = branch_q + CNT_W'(1);
            end
            if (taken && !(&taken_q)) begin
                taken_d = taken_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            target_q <= '0;
            branch_q <= '0;
            taken_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            branch_q <= branch_d;
            taken_q  <= taken_d;
        end
    end

    // All outputs come straight from registers.
    assign pc_redirect_valid  = (state_q == StRedirect);
    assign pc_redirect_target = target_q;
    assign flush_if_id        = (state_q != StIdle);
    assign flush_id_ex        = (state_q != StIdle);
    assign busy               = (state_q != StIdle);
    assign branch_count       = branch_q;
    assign taken_count        = taken_q;

endmodule

// File: tb/tb_mem_branch_resolver.sv
// Self-checking bench for mem_branch_resolver: directed scenarios plus random
// traffic compared against a countdown-based reference model.
module tb_mem_branch_resolver;

    localparam int unsigned XLEN = 32;
    localparam int unsigned FC   = 2;
    localparam int unsigned CW   = 4;
    localparam int unsigned VW   = 1 + XLEN + 3 + 2 * CW;
    localparam int          CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            mem_valid, stall, Jump, Branch, InverseBranch, Zero, cnt_clear;
    logic [XLEN-1:0] jump_target;
    logic            pc_redirect_valid, flush_if_id, flush_id_ex, busy;
    logic [XLEN-1:0] pc_redirect_target;
    logic [CW-1:0]   branch_count, taken_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: cycles of busy time remaining, latched target, counts.
    int              m_left;
    logic [XLEN-1:0] m_target;
    int              m_branch, m_taken;

    mem_branch_resolver #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .mem_valid         (mem_valid),
        .stall             (stall),
        .Jump              (Jump),
        .Branch            (Branch),
        .InverseBranch     (InverseBranch),
        .Zero              (Zero),
        .jump_target       (jump_target),
        .cnt_clear         (cnt_clear),
        .pc_redirect_valid (pc_redirect_valid),
        .pc_redirect_target(pc_redirect_target),
        .flush_if_id       (flush_if_id),
        .flush_id_ex       (flush_id_ex),
        .busy              (busy),
        .branch_count      (branch_count),
        .taken_count       (taken_count)
    );

    always #5 clk = ~clk;

    logic [VW-1:0] obs;
    assign obs = {pc_redirect_valid, pc_redirect_target, flush_if_id, flush_id_ex, busy,
                  branch_count, taken_count};

    function automatic logic [VW-1:0] expv();
        logic b;
        b = (m_left != 0);
        return {(m_left == FC), m_target, b, b, b, CW'(m_branch), CW'(m_taken)};
    endfunction

    task automatic model_reset();
        m_left   = 0;
        m_target = '0;
        m_branch = 0;
        m_taken  = 0;
    endtask

    // Apply one cycle of inputs, clock it, and advance the model.
    task automatic tick(input logic mv, input logic st, input logic j, input logic b,
                        input logic inv, input logic z, input logic [XLEN-1:0] tgt,
                        input logic clr);
        logic acc, tk;
        mem_valid = mv; stall = st; Jump = j; Branch = b; InverseBranch = inv; Zero = z;
        jump_target = tgt; cnt_clear = clr;
        @(posedge clk);
        acc = mv && !st && (m_left == 0);
        tk  = j || (b && (z != inv));
        if (clr) begin
            m_branch = 0;
            m_taken  = 0;
        end else if (acc) begin
            if (b && !j) m_branch = (m_branch < CMAX) ? m_branch + 1 : CMAX;
            if (tk)      m_taken  = (m_taken  < CMAX) ? m_taken  + 1 : CMAX;
        end
        if (m_left > 0) begin
            if (!st) m_left = m_left - 1;
        end else if (acc && tk) begin
            m_left   = FC;
            m_target = tgt & ~XLEN'(1);
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, '0, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        tick(0, 0, 0, 0, 0, 0, '0, 0);
        n_cmp++;
        if (obs !== '0) begin
            n_bad++;
            $display("FAIL reset: got %h want 0", obs);
        end
        #2 rst_n = 1'b1;
        idle(1);
        n_cmp++;
        if (obs !== expv()) begin
            n_bad++;
            $display("FAIL reset_release: got %h want %h", obs, expv());
        end
    endtask

    task automatic test_taken_branch();
        tick(1, 0, 0, 1, 0, 1, 32'h40, 0);
        n_cmp++;
        if (!(pc_redirect_valid === 1'b1 && pc_redirect_target === 32'h40 && flush_if_id === 1'b1
              && flush_id_ex === 1'b1)) begin
            n_bad++;
            $display("FAIL t1_redirect: got v=%b t=%h f=%b%b want v=1 t=40 f=11",
                     pc_redirect_valid, pc_redirect_target, flush_if_id, flush_id_ex);
        end
        // A taken branch offered while busy must be ignored.
        tick(1, 0, 0, 1, 0, 1, 32'h80, 0);
        n_cmp++;
        if (!(pc_redirect_valid === 1'b0 && flush_if_id === 1'b1 && flush_id_ex === 1'b1)) begin
            n_bad++;
            $display("FAIL t1_flush: got v=%b f=%b%b want v=0 f=11",
                     pc_redirect_valid, flush_if_id, flush_id_ex);
        end
        tick(1, 0, 0, 1, 0, 1, 32'h80, 0);
        n_cmp++;
        if (obs !== expv() || busy !== 1'b0 || branch_count !== 4'd1 || taken_count !== 4'd1) begin
            n_bad++;
            $display("FAIL t1_done: got %h want %h (busy 0, counts 1/1)", obs, expv());
        end
        idle(3);
    endtask

    task automatic test_not_taken();
        tick(1, 0, 0, 1, 1, 1, 32'h200, 0);
        n_cmp++;
        if (obs !== expv() || busy !== 1'b0 || branch_count !== 4'd2 || taken_count !== 4'd1) begin
            n_bad++;
            $display("FAIL t2_not_taken: got %h want %h", obs, expv());
        end
    endtask

    task automatic test_jump_priority();
        tick(1, 0, 1, 1, 0, 0, 32'h1003, 0);
        n_cmp++;
        if (pc_redirect_valid !== 1'b1 || pc_redirect_target !== 32'h1002 || obs !== expv()
            || branch_count !== 4'd2 || taken_count !== 4'd2) begin
            n_bad++;
            $display("FAIL t3_jump: got %h want %h (target 1002)", obs, expv());
        end
        idle(2);
    endtask

    task automatic test_stall_redirect();
        int rcnt, fcnt;
        rcnt = 0;
        fcnt = 0;
        tick(1, 0, 0, 1, 0, 1, 32'h300, 0);
        if (pc_redirect_valid === 1'b1) rcnt++;
        for (int i = 0; i < 3; i++) begin
            tick(1, 1, 1, 0, 0, 0, 32'h500, 0);
            if (pc_redirect_valid === 1'b1) rcnt++;
        end
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 0, 0, 0, '0, 0);
            if (pc_redirect_valid === 1'b0 && flush_if_id === 1'b1) fcnt++;
        end
        n_cmp++;
        if (rcnt != 4 || fcnt != 1 || busy !== 1'b0 || pc_redirect_target !== 32'h300) begin
            n_bad++;
            $display("FAIL t4_stall: got redirect=%0d flush=%0d busy=%b want 4/1/0",
                     rcnt, fcnt, busy);
        end
    endtask

    task automatic test_saturate_clear();
        tick(0, 0, 0, 0, 0, 0, '0, 1);
        for (int i = 0; i < 20; i++) begin
            tick(1, 0, 1, 0, 0, 0, 32'(i * 16), 0);
            idle(2);
        end
        n_cmp++;
        if (taken_count !== 4'd15 || obs !== expv()) begin
            n_bad++;
            $display("FAIL t5_saturate: got taken=%0d want 15", taken_count);
        end
        // Clear beats a simultaneous accept.
        tick(1, 0, 1, 1, 0, 0, 32'h10, 1);
        n_cmp++;
        if (taken_count !== 4'd0 || branch_count !== 4'd0 || obs !== expv()) begin
            n_bad++;
            $display("FAIL t5_clear: got %0d/%0d want 0/0", branch_count, taken_count);
        end
        idle(2);
    endtask

    task automatic test_async_reset();
        tick(1, 0, 1, 0, 0, 0, 32'h777, 0);
        tick(0, 0, 0, 0, 0, 0, '0, 0);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (obs !== '0) begin
            n_bad++;
            $display("FAIL t6_async: got %h want 0", obs);
        end
        #2 rst_n = 1'b1;
        idle(3);
        n_cmp++;
        if (busy !== 1'b0 || obs !== expv()) begin
            n_bad++;
            $display("FAIL t6_release: got %h want %h", obs, expv());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(3, 0) != 0), ($urandom_range(3, 0) == 0),
                 ($urandom_range(3, 0) == 0), $urandom_range(1, 0), $urandom_range(1, 0),
                 $urandom_range(1, 0), $urandom, ($urandom_range(40, 0) == 0));
            n_cmp++;
            if (obs !== expv()) begin
                n_bad++;
                $display("FAIL random[%0d]: got %h want %h", i, obs, expv());
            end
        end
    endtask

    initial begin
        mem_valid = 0; stall = 0; Jump = 0; Branch = 0; InverseBranch = 0; Zero = 0;
        jump_target = '0; cnt_clear = 0;
        test_reset();
        test_taken_branch();
        test_not_taken();
        test_jump_priority();
        test_stall_redirect();
        test_saturate_clear();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
